mmio_port_bridge: RTL and testbench

Device-side end of the processor's memory-mapped I/O port. The memory block's `processor_output` and `processor_input` words are the CPU side of this bridge. The bridge buffers words the CPU stores to the output address in a transmit FIFO and drains them to an external consumer over a valid/ready handshake. It also accepts words from an external producer into a receive FIFO and presents the oldest one on `processor_input` until the CPU reads it.

---
 rtl/mmio_port_bridge_if.sv | 31 +++
 rtl/mmio_port_bridge.sv | 97 +++++++++
 tb/tb_mmio_port_bridge.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_port_bridge_if.sv
// rtl/mmio_port_bridge_if.sv - CPU-side and external-side signals of the MMIO port bridge
interface mmio_port_bridge_if;
  logic [15:0] cpu_out_data;
  logic        cpu_out_we;
  logic        cpu_in_re;
  logic [15:0] processor_input;
  logic        rx_empty;
  logic [15:0] ext_tx_data;
  logic        ext_tx_valid;
  logic        ext_tx_ready;
  logic [15:0] ext_rx_data;
  logic        ext_rx_valid;
  logic        ext_rx_ready;
  logic        flag_clr;
  logic        tx_overflow;
  logic        rx_underflow;

  modport slave (
    input  cpu_out_data, cpu_out_we, cpu_in_re, ext_tx_ready,
           ext_rx_data, ext_rx_valid, flag_clr,
    output processor_input, rx_empty, ext_tx_data, ext_tx_valid,
           ext_rx_ready, tx_overflow, rx_underflow
  );

  modport master (
    output cpu_out_data, cpu_out_we, cpu_in_re, ext_tx_ready,
           ext_rx_data, ext_rx_valid, flag_clr,
    input  processor_input, rx_empty, ext_tx_data, ext_tx_valid,
           ext_rx_ready, tx_overflow, rx_underflow
  );
endinterface

// File: rtl/mmio_port_bridge.sv
// rtl/mmio_port_bridge.sv - TX/RX FIFOs between the CPU MMIO port and external valid/ready streams
module mmio_port_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             CLK,
  input  logic             RST,
  mmio_port_bridge_if.slave bus
);

  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [15:0]   tx_mem [DEPTH];
  logic [15:0]   rx_mem [DEPTH];
  logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
  logic [AW:0]   tx_cnt, rx_cnt;
  logic          tx_ovf_q, rx_udf_q;

  logic tx_push, tx_pop, tx_ovf_evt;
  logic rx_push, rx_pop, rx_udf_evt;
  logic tx_nonempty, rx_nonempty;

  // Handshake qualification; a TX store into a full FIFO is still taken when the head leaves this cycle
  always_comb begin
    tx_nonempty      = (tx_cnt != '0);
    rx_nonempty      = (rx_cnt != '0);
    bus.ext_rx_ready = !RST && (rx_cnt != FULL);
    tx_pop           = tx_nonempty && bus.ext_tx_ready;
    tx_push          = bus.cpu_out_we && ((tx_cnt != FULL) || tx_pop);
    tx_ovf_evt       = bus.cpu_out_we && !tx_push;
    rx_push          = bus.ext_rx_valid && bus.ext_rx_ready;
    rx_pop           = bus.cpu_in_re && rx_nonempty;
    rx_udf_evt       = bus.cpu_in_re && !rx_nonempty;
  end

  // Outputs decode from registered state only
  always_comb begin
    bus.ext_tx_valid    = tx_nonempty;
    bus.ext_tx_data     = tx_mem[tx_rd];
    bus.rx_empty        = !rx_nonempty;
    bus.processor_input = rx_nonempty ? rx_mem[rx_rd] : 16'h0000;
    bus.tx_overflow     = tx_ovf_q;
    bus.rx_underflow    = rx_udf_q;
  end

  // FIFO storage carries no reset; stale contents are masked by the counts
  always_ff @(posedge CLK) begin
    if (tx_push) tx_mem[tx_wr] <= bus.cpu_out_data;
    if (rx_push) rx_mem[rx_wr] <= bus.ext_rx_data;
  end

  // TX pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)  tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // RX pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_rd  <= '0;
      rx_wr  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_evt || (tx_ovf_q && !bus.flag_clr);
      rx_udf_q <= rx_udf_evt || (rx_udf_q && !bus.flag_clr);
    end
  end

endmodule

// File: tb/tb_mmio_port_bridge.sv
// tb/tb_mmio_port_bridge.sv - randomized and directed bench with a queue-based reference model
module tb_mmio_port_bridge;
  localparam int DEPTH = 4;

  logic CLK = 1'b0;
  logic RST;
  mmio_port_bridge_if bus ();

  mmio_port_bridge #(.DEPTH(DEPTH), .AW(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: two queues and two flags
  logic [15:0] txq[$];
  logic [15:0] rxq[$];
  bit m_ovf, m_udf;
  int tx_n, rx_n;
  bit m_tx_pop, m_tx_push, m_rx_push, m_rx_pop;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      txq.delete();
      rxq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      tx_n      = txq.size();
      rx_n      = rxq.size();
      m_tx_pop  = (tx_n > 0) && bus.ext_tx_ready;
      m_tx_push = bus.cpu_out_we && ((tx_n < DEPTH) || m_tx_pop);
      m_rx_push = bus.ext_rx_valid && (rx_n < DEPTH);
      m_rx_pop  = bus.cpu_in_re && (rx_n > 0);
      if (bus.flag_clr) begin
        m_ovf = 0;
        m_udf = 0;
      end
      if (bus.cpu_out_we && !m_tx_push) m_ovf = 1;
      if (bus.cpu_in_re && rx_n == 0) m_udf = 1;
      if (m_tx_pop) void'(txq.pop_front());
      if (m_tx_push) txq.push_back(bus.cpu_out_data);
      if (m_rx_pop) void'(rxq.pop_front());
      if (m_rx_push) rxq.push_back(bus.ext_rx_data);
    end
  end

  // Compare every output against the model, away from the active edge
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("ext_tx_valid", {31'd0, bus.ext_tx_valid}, {31'd0, txq.size() > 0});
      if (txq.size() > 0) chk("ext_tx_data", {16'd0, bus.ext_tx_data}, {16'd0, txq[0]});
      chk("rx_empty", {31'd0, bus.rx_empty}, {31'd0, rxq.size() == 0});
      chk("processor_input", {16'd0, bus.processor_input},
          {16'd0, (rxq.size() > 0) ? rxq[0] : 16'h0000});
      chk("ext_rx_ready", {31'd0, bus.ext_rx_ready}, {31'd0, !RST && rxq.size() < DEPTH});
      chk("tx_overflow", {31'd0, bus.tx_overflow}, {31'd0, m_ovf});
      chk("rx_underflow", {31'd0, bus.rx_underflow}, {31'd0, m_udf});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    bus.cpu_out_we   = 0;
    bus.cpu_in_re    = 0;
    bus.ext_tx_ready = 0;
    bus.ext_rx_valid = 0;
    bus.flag_clr     = 0;
  endtask

  task automatic do_reset();
    RST = 1;
    idle();
    tick();
    tick();
    RST = 0;
  endtask

  initial begin
    RST = 1;
    idle();
    bus.cpu_out_data = 16'h0;
    bus.ext_rx_data  = 16'h0;
    tick();
    chk_en = 1;
    tick();
    chk("reset rx_empty", {31'd0, bus.rx_empty}, 32'd1);
    chk("reset tx_valid", {31'd0, bus.ext_tx_valid}, 32'd0);
    chk("reset rx_ready", {31'd0, bus.ext_rx_ready}, 32'd0);
    chk("reset pi", {16'd0, bus.processor_input}, 32'h0);
    RST = 0;

    // TX order and latency
    bus.cpu_out_we = 1; bus.cpu_out_data = 16'h1111; tick();
    chk("tx first valid", {31'd0, bus.ext_tx_valid}, 32'd1);
    chk("tx first data", {16'd0, bus.ext_tx_data}, 32'h1111);
    bus.cpu_out_data = 16'h2222; tick();
    bus.cpu_out_data = 16'h3333; tick();
    bus.cpu_out_we = 0; bus.ext_tx_ready = 1;
    chk("tx head before pop", {16'd0, bus.ext_tx_data}, 32'h1111);
    tick();
    chk("tx second", {16'd0, bus.ext_tx_data}, 32'h2222);
    tick();
    chk("tx third", {16'd0, bus.ext_tx_data}, 32'h3333);
    tick();
    chk("tx valid drops", {31'd0, bus.ext_tx_valid}, 32'd0);
    bus.ext_tx_ready = 0;

    // TX overflow
    for (int i = 0; i < 5; i++) begin
      bus.cpu_out_we = 1; bus.cpu_out_data = 16'h00A0 + 16'(i);
      tick();
      if (i == 3) chk("no ovf at full", {31'd0, bus.tx_overflow}, 32'd0);
    end
    chk("tx_overflow set", {31'd0, bus.tx_overflow}, 32'd1);
    bus.cpu_out_we = 0; bus.ext_tx_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf drain", {16'd0, bus.ext_tx_data}, 32'h00A0 + i);
      tick();
    end
    chk("ovf drained", {31'd0, bus.ext_tx_valid}, 32'd0);
    bus.ext_tx_ready = 0; bus.flag_clr = 1; tick(); bus.flag_clr = 0;
    chk("tx_overflow cleared", {31'd0, bus.tx_overflow}, 32'd0);

    // TX push on full with simultaneous pop
    for (int i = 0; i < 4; i++) begin
      bus.cpu_out_we = 1; bus.cpu_out_data = 16'h00C0 + 16'(i); tick();
    end
    bus.cpu_out_data = 16'hBEEF; bus.ext_tx_ready = 1; tick();
    bus.cpu_out_we = 0;
    chk("push-through no ovf", {31'd0, bus.tx_overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("push-through order", {16'd0, bus.ext_tx_data}, (i == 3) ? 32'hBEEF : 32'h00C1 + i);
      tick();
    end
    chk("push-through empty", {31'd0, bus.ext_tx_valid}, 32'd0);
    bus.ext_tx_ready = 0;

    // RX path and underflow
    bus.ext_rx_valid = 1; bus.ext_rx_data = 16'h00AA; tick();
    bus.ext_rx_data = 16'h00BB; tick();
    bus.ext_rx_valid = 0;
    chk("rx head AA", {16'd0, bus.processor_input}, 32'h00AA);
    bus.cpu_in_re = 1; tick();
    chk("rx head BB", {16'd0, bus.processor_input}, 32'h00BB);
    tick();
    chk("rx drained pi", {16'd0, bus.processor_input}, 32'h0);
    chk("rx drained empty", {31'd0, bus.rx_empty}, 32'd1);
    chk("no udf yet", {31'd0, bus.rx_underflow}, 32'd0);
    tick();
    bus.cpu_in_re = 0;
    chk("rx_underflow set", {31'd0, bus.rx_underflow}, 32'd1);
    chk("udf pi zero", {16'd0, bus.processor_input}, 32'h0);
    bus.flag_clr = 1; tick(); bus.flag_clr = 0;

    // RX full and wrap
    bus.ext_rx_valid = 1;
    for (int i = 0; i < 4; i++) begin
      bus.ext_rx_data = 16'h00D0 + 16'(i); tick();
    end
    bus.ext_rx_valid = 0;
    chk("rx full ready low", {31'd0, bus.ext_rx_ready}, 32'd0);
    bus.cpu_in_re = 1; tick(); tick();
    bus.ext_rx_valid = 1;
    for (int i = 0; i < 12; i++) begin
      bus.ext_rx_data = 16'h00E0 + 16'(i); tick();
    end
    chk("rx wrap head", {16'd0, bus.processor_input}, 32'h00EA);
    bus.ext_rx_valid = 0; tick(); tick();
    bus.cpu_in_re = 0;

    // Async reset between edges with both FIFOs occupied
    bus.cpu_out_we = 1; bus.cpu_out_data = 16'h7777;
    bus.ext_rx_valid = 1; bus.ext_rx_data = 16'h8888; tick();
    idle();
    @(posedge CLK);
    #1;
    RST = 1;
    #1;
    chk("async tx_valid", {31'd0, bus.ext_tx_valid}, 32'd0);
    chk("async rx_empty", {31'd0, bus.rx_empty}, 32'd1);
    chk("async pi", {16'd0, bus.processor_input}, 32'h0);
    chk("async rx_ready", {31'd0, bus.ext_rx_ready}, 32'd0);
    tick();
    RST = 0;
    bus.cpu_out_we = 1; bus.cpu_out_data = 16'h5A5A; tick();
    bus.cpu_out_we = 0;
    chk("post-reset store", {16'd0, bus.ext_tx_data}, 32'h5A5A);
    bus.ext_tx_ready = 1; tick(); bus.ext_tx_ready = 0;

    // Randomized traffic with changing bias to hit full and empty regularly
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 200) % 3;
      bus.cpu_out_we   = ($urandom_range(0, 3) < (bias == 0 ? 3 : 1));
      bus.cpu_out_data = 16'($urandom);
      bus.ext_tx_ready = ($urandom_range(0, 3) < (bias == 1 ? 3 : 1));
      bus.ext_rx_valid = ($urandom_range(0, 3) < (bias == 0 ? 3 : 2));
      bus.ext_rx_data  = 16'($urandom);
      bus.cpu_in_re    = ($urandom_range(0, 3) < (bias == 2 ? 3 : 1));
      bus.flag_clr     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    idle();
    tick();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
